// File: rtl/stream_width_downsizer.sv
// -----------------------------------------------------------------------------
// stream_width_downsizer
//
// Drains IN_WIDTH-bit AXI-Stream words from a StreamingFIFO and re-emits each
// word as RATIO = IN_WIDTH/OUT_WIDTH narrower beats, least-significant slice
// first. It sustains one output beat per cycle. Consecutive words chain
// without a bubble: the next word is accepted on the same edge that the last
// slice of the current word is consumed.
//
// Ports
//   ap_clk        in   1          sole clock, rising edge
//   ap_rst        in   1          synchronous, active-high reset
//   in0_V_TDATA   in   IN_WIDTH   input word
//   in0_V_TVALID  in   1          input word valid
//   in0_V_TREADY  out  1          input word accepted this cycle
//   out_V_TDATA   out  OUT_WIDTH  current output slice
//   out_V_TVALID  out  1          output slice valid
//   out_V_TREADY  in   1          downstream accepts the slice
// -----------------------------------------------------------------------------
module stream_width_downsizer #(
   parameter int IN_WIDTH  = 32,
   parameter int OUT_WIDTH = 8
) (
   input  logic                 ap_clk,
   input  logic                 ap_rst,
   input  logic [IN_WIDTH-1:0]  in0_V_TDATA,
   input  logic                 in0_V_TVALID,
   output logic                 in0_V_TREADY,
   output logic [OUT_WIDTH-1:0] out_V_TDATA,
   output logic                 out_V_TVALID,
   input  logic                 out_V_TREADY
);

   localparam int RATIO = (OUT_WIDTH > 0) ? (IN_WIDTH / OUT_WIDTH) : 0;
   localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);

   // Reject widths that do not split into at least two whole slices.
   generate
      if ((OUT_WIDTH < 1) || (RATIO < 2) || ((IN_WIDTH % OUT_WIDTH) != 0)) begin : g_bad_params
         $error("stream_width_downsizer: IN_WIDTH must be an integer multiple (>=2) of OUT_WIDTH");
      end
   endgenerate

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_HOLD  = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [IN_WIDTH-1:0]   r_hold;
   logic [IN_WIDTH-1:0]   w_hold_nxt;
   logic [IDX_W-1:0]      r_idx;
   logic [IDX_W-1:0]      w_idx_nxt;
   logic                  w_valid;
   logic                  w_last;
   logic                  w_in_ready;
   logic                  w_in_fire;
   logic                  w_out_fire;
   logic [OUT_WIDTH-1:0]  w_slice;

   // Handshake decode. Ready depends only on state, reset and the downstream
   // ready, never on in0_V_TVALID/TDATA. The path from out_V_TREADY is what
   // lets a new word chain onto the last slice without a bubble.
   always_comb begin
      w_valid    = (r_state == S_HOLD);
      w_last     = w_valid && (r_idx == IDX_LAST);
      w_in_ready = !ap_rst && (!w_valid || (w_last && out_V_TREADY));
      w_in_fire  = in0_V_TVALID && w_in_ready;
      w_out_fire = w_valid && out_V_TREADY;
   end

   // Next-state logic. An input fire always wins. On a chained cycle the last
   // slice leaves and the new word lands with idx back at 0.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_hold_nxt  = r_hold;
      if (w_in_fire) begin
         w_state_nxt = S_HOLD;
         w_idx_nxt   = '0;
         w_hold_nxt  = in0_V_TDATA;
      end else if (w_out_fire) begin
         if (w_last) begin
            w_state_nxt = S_EMPTY;
            w_idx_nxt   = '0;
         end else begin
            w_idx_nxt   = r_idx + IDX_W'(1);
         end
      end
   end

   // Slice select. Index values >= RATIO are unreachable when RATIO is not a
   // power of two; they fall through to zero.
   always_comb begin
      w_slice = '0;
      for (int i = 0; i < RATIO; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_slice = r_hold[i*OUT_WIDTH +: OUT_WIDTH];
         end
      end
   end

   // State register. The hold register is also cleared so that out_V_TDATA
   // reads zero after reset, and any half-emitted word is dropped.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_state <= S_EMPTY;
         r_idx   <= '0;
         r_hold  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_hold  <= w_hold_nxt;
      end
   end

   assign in0_V_TREADY = w_in_ready;
   assign out_V_TVALID = w_valid;
   assign out_V_TDATA  = w_slice;

endmodule

// File: tb/tb_stream_width_downsizer.sv
// -----------------------------------------------------------------------------
// tb_stream_width_downsizer
//
// Drives a 32->8 instance and a 32->16 instance of stream_width_downsizer.
// Accepted words are split into expected slices and pushed to a per-instance
// queue. Every output handshake pops and compares against that queue.
// Directed checks cover latency, chaining, backpressure and reset.
// -----------------------------------------------------------------------------
module tb_stream_width_downsizer;

   logic        clk = 1'b0;
   logic        rst;

   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;

   logic [31:0] in16_data;
   logic        in16_valid;
   logic        in16_ready;
   logic [15:0] out16_data;
   logic        out16_valid;
   logic        out16_ready;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] q8[$];
   logic [31:0] q16[$];

   always #5 clk = ~clk;

   stream_width_downsizer #(.IN_WIDTH(32), .OUT_WIDTH(8)) u_dut8 (
      .ap_clk       (clk),
      .ap_rst       (rst),
      .in0_V_TDATA  (in_data),
      .in0_V_TVALID (in_valid),
      .in0_V_TREADY (in_ready),
      .out_V_TDATA  (out_data),
      .out_V_TVALID (out_valid),
      .out_V_TREADY (out_ready)
   );

   stream_width_downsizer #(.IN_WIDTH(32), .OUT_WIDTH(16)) u_dut16 (
      .ap_clk       (clk),
      .ap_rst       (rst),
      .in0_V_TDATA  (in16_data),
      .in0_V_TVALID (in16_valid),
      .in0_V_TREADY (in16_ready),
      .out_V_TDATA  (out16_data),
      .out_V_TVALID (out16_valid),
      .out_V_TREADY (out16_ready)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboards, sampled mid-cycle where all inputs are stable.
   always @(negedge clk) begin
      if (rst) begin
         q8.delete();
         q16.delete();
      end else begin
         if (out_valid && out_ready) begin
            check("sb8_beat_expected", 64'(q8.size() != 0), 64'd1);
            if (q8.size() != 0) check("sb8_beat_data", 64'(out_data), 64'(q8.pop_front()));
         end
         if (in_valid && in_ready) begin
            for (int i = 0; i < 4; i++) q8.push_back(32'(in_data[i*8 +: 8]));
         end
         if (out16_valid && out16_ready) begin
            check("sb16_beat_expected", 64'(q16.size() != 0), 64'd1);
            if (q16.size() != 0) check("sb16_beat_data", 64'(out16_data), 64'(q16.pop_front()));
         end
         if (in16_valid && in16_ready) begin
            for (int i = 0; i < 2; i++) q16.push_back(32'(in16_data[i*16 +: 16]));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for the edge on which the presented word is accepted; returns the
   // number of edges waited (0 on timeout, which is reported).
   task automatic wait_accept(input bit w16, output int cycles);
      logic r;
      cycles = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         r = w16 ? in16_ready : in_ready;
         @(posedge clk);
         #1;
         if (r) begin
            cycles = i;
            break;
         end
      end
      if (cycles == 0) check(w16 ? "accept16_timeout" : "accept8_timeout", 64'd0, 64'd1);
   endtask

   task automatic send8(input logic [31:0] d);
      int c;
      in_data  = d;
      in_valid = 1'b1;
      wait_accept(1'b0, c);
      in_valid = 1'b0;
   endtask

   task automatic drain8();
      bit done = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (!out_valid) begin
            done = 1'b1;
            break;
         end
         tick();
      end
      check("drain8_done", 64'(done), 64'd1);
   endtask

   initial begin
      int c;
      rst         = 1'b1;
      in_data     = '0;
      in_valid    = 1'b0;
      out_ready   = 1'b1;
      in16_data   = '0;
      in16_valid  = 1'b0;
      out16_ready = 1'b1;

      // Reset state
      tick();
      tick();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data",  64'(out_data),  64'd0);
      check("rst_in_ready",  64'(in_ready),  64'd0);
      check("rst_in16_ready", 64'(in16_ready), 64'd0);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", 64'(in_ready), 64'd1);

      // Single word, free-running output
      send8(32'h44332211);
      check("t1_latency_valid", 64'(out_valid), 64'd1);
      check("t1_slice0",        64'(out_data),  64'h11);
      for (int i = 1; i < 4; i++) begin
         tick();
         check("t1_no_bubble", 64'(out_valid), 64'd1);
      end
      tick();
      check("t1_empty_valid", 64'(out_valid), 64'd0);
      check("t1_empty_ready", 64'(in_ready),  64'd1);

      // Back-to-back words chain with no bubble
      send8(32'hDDCCBBAA);
      in_data  = 32'h87654321;
      in_valid = 1'b1;
      wait_accept(1'b0, c);
      in_valid = 1'b0;
      check("t2_chain_edge",  64'(c),         64'd4);
      check("t2_chain_valid", 64'(out_valid), 64'd1);
      check("t2_chain_slice", 64'(out_data),  64'h21);
      drain8();

      // Backpressure on slice 1 with a new word waiting upstream
      send8(32'h44332211);
      tick();
      check("t3_slice1", 64'(out_data), 64'h22);
      out_ready = 1'b0;
      in_data   = 32'h0D0C0B0A;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t3_stall_valid", 64'(out_valid), 64'd1);
         check("t3_stall_data",  64'(out_data),  64'h22);
         check("t3_stall_ready", 64'(in_ready),  64'd0);
      end
      out_ready = 1'b1;
      wait_accept(1'b0, c);
      in_valid = 1'b0;
      check("t4_accept_after_last", 64'(c),        64'd3);
      check("t4_new_slice0",        64'(out_data), 64'h0A);
      drain8();

      // Reset mid-word discards the remaining slices
      send8(32'h44332211);
      tick();
      check("t5_slice1", 64'(out_data), 64'h22);
      rst = 1'b1;
      #1;
      check("t5_rst_in_ready", 64'(in_ready), 64'd0);
      tick();
      check("t5_rst_valid",    64'(out_valid), 64'd0);
      check("t5_rst_data",     64'(out_data),  64'd0);
      check("t5_rst_in_ready2", 64'(in_ready), 64'd0);
      rst = 1'b0;
      #1;
      check("t5_rel_in_ready", 64'(in_ready), 64'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t5_no_stale_beat", 64'(out_valid), 64'd0);
      end
      send8(32'h99887766);
      check("t5_fresh_slice0", 64'(out_data), 64'h66);
      drain8();

      // 16-bit output: two slices per word, idx wraps at 1
      in16_data  = 32'hCAFEBABE;
      in16_valid = 1'b1;
      wait_accept(1'b1, c);
      in16_data  = 32'h12345678;
      check("t6_slice0_valid", 64'(out16_valid), 64'd1);
      check("t6_slice0",       64'(out16_data),  64'hBABE);
      wait_accept(1'b1, c);
      in16_valid = 1'b0;
      check("t6_chain_edge",  64'(c),          64'd2);
      check("t6_next_slice0", 64'(out16_data), 64'h5678);
      tick();
      check("t6_next_slice1", 64'(out16_data), 64'h1234);
      tick();
      check("t6_empty", 64'(out16_valid), 64'd0);

      tick();
      check("sb8_drained",  64'(q8.size()),  64'd0);
      check("sb16_drained", 64'(q16.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/stream_width_downsizer.md
# stream_width_downsizer

Consumer-side stage that drains a 32-bit AXI-Stream StreamingFIFO output and re-emits each word as a sequence of narrower AXI-Stream beats, least-significant slice first. It sits between a StreamingFIFO and a narrower downstream layer or DMA port in the FINN dataflow chain. It is the reader for the FIFO's writer side. It provides full throughput: one output beat per cycle with no bubbles between words.

## Interface
- IN_WIDTH, 32, input word width in bits
- OUT_WIDTH, 8, output beat width in bits. IN_WIDTH must be an integer multiple of OUT_WIDTH, with RATIO = IN_WIDTH/OUT_WIDTH ≥ 2. Otherwise elaboration fails.

Ports (reset is synchronous and active-high):
- ap_clk  input  1  sole clock; all state updates on the rising edge
- ap_rst  input  1  synchronous, active-high reset
- in0_V_TDATA  input  IN_WIDTH  input word
- in0_V_TVALID  input  1  input word valid
- in0_V_TREADY  output  1  block accepts the input word this cycle
- out_V_TDATA  output  OUT_WIDTH  current output slice
- out_V_TVALID  output  1  output slice valid
- out_V_TREADY  input  1  downstream accepts the slice

## Operation
- State registers:
  - hold: IN_WIDTH bits
  - valid_r: 1 bit
  - idx: ceil(log2(RATIO)) bits, range 0..RATIO-1
- States:
  - EMPTY: valid_r=0
  - HOLD: valid_r=1
- Outputs:
  - out_V_TVALID = valid_r
  - out_V_TDATA = hold[idx*OUT_WIDTH +: OUT_WIDTH]
- last = valid_r && idx==RATIO-1.
- in0_V_TREADY = !ap_rst && (!valid_r || (last && out_V_TREADY)). This is a combinational path from out_V_TREADY and is intentional.
- Input fire (in0_V_TVALID && in0_V_TREADY):
  - hold ← in0_V_TDATA, valid_r ← 1, idx ← 0.
  - This takes priority over the output-side update in the same cycle.
- Output fire without input fire (out_V_TVALID && out_V_TREADY):
  - If not last: idx ← idx+1.
  - If last: valid_r ← 0, idx ← 0 (go to EMPTY).
- Transitions:
  - EMPTY→HOLD on input fire.
  - HOLD→HOLD on non-last output fire, or on last output fire coinciding with input fire (word chaining).
  - HOLD→EMPTY on last output fire with no input fire.
- A word is never accepted while non-last slices remain unconsumed. in0_V_TVALID in that case is simply not acknowledged.
- Reset (ap_rst=1 at an edge): valid_r←0, idx←0, hold←0.
  - Any partially emitted word is discarded; no further slices of it appear.
  - in0_V_TREADY is 0 during every cycle ap_rst is high, so no word is accepted while reset is held.

## Timing
- Reset values:
  - out_V_TVALID=0
  - out_V_TDATA=0
  - in0_V_TREADY=0 while ap_rst=1, and 1 in the first cycle after ap_rst deasserts.
- Latency: a word accepted at edge k presents slice 0 on out_V_TDATA with out_V_TVALID=1 during cycle k+1.
- Throughput: with out_V_TREADY held high and the input continuously valid, output is RATIO beats per word back-to-back. Slice 0 of word n+1 follows slice RATIO-1 of word n with zero bubble cycles.
- Backpressure:
  - While out_V_TVALID=1 and out_V_TREADY=0, out_V_TDATA and out_V_TVALID hold stable (AXI-Stream rule).
  - idx does not advance.
  - in0_V_TREADY=0 unless the block is in EMPTY.
- An upstream TVALID drop mid-stream only creates EMPTY cycles. No slice is duplicated or skipped.
- No combinational path exists from in0_V_TVALID or in0_V_TDATA to any output.

## Test plan
- Reset release, then one word 0x44332211 with out_V_TREADY=1 -> beats 0x11, 0x22, 0x33, 0x44 on consecutive cycles starting 1 cycle after acceptance; then out_V_TVALID=0 and in0_V_TREADY=1.
- Words 0xDDCCBBAA and 0x87654321 presented back-to-back with out_V_TREADY=1 -> eight consecutive beats AA BB CC DD 21 43 65 87 with no bubble; the second word is accepted on the same edge that 0xDD is consumed.
- Same single word with out_V_TREADY=0 for 3 cycles while 0x22 is presented -> 0x22 held stable with TVALID=1 for all 3 cycles; in0_V_TREADY=0 throughout; output resumes with 0x33.
- in0_V_TVALID held high with a new word while idx=1 -> no acceptance until the 0x44 beat fires; the new word's slice 0 appears the next cycle.
- ap_rst pulsed for 1 cycle after beat 0x22 -> the next cycle shows out_V_TVALID=0 and in0_V_TREADY=0 during reset; no 0x33/0x44 ever emitted; a fresh word afterwards streams correctly from slice 0.
- OUT_WIDTH=16 with word 0xCAFEBABE -> beats 0xBABE then 0xCAFE; idx wraps at 1.
